// File: rtl/ns_pkg.sv
// -----------------------------------------------------------------------------
// ns_pkg
// Shared project package for the neural-network output stage.
//   NS_N_CLASSES : default number of output-neuron scores per inference
//   NS_DATA_W    : default signed score width (matches neuron data_out)
//   state_t      : argmax classifier FSM state encoding
// -----------------------------------------------------------------------------
package ns_pkg;

    localparam int NS_N_CLASSES = 10;
    localparam int NS_DATA_W    = 32;

    // COLLECT: accepting scores; HOLD: presenting a result downstream.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// -----------------------------------------------------------------------------
// argmax_classifier_if
// Bundles the score input stream and the result output stream.
//   in_valid / in_ready / in_data / in_last  : score stream into the classifier
//   out_valid / out_ready                    : result handshake
//   class_idx / class_score / frame_err      : result payload
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds its payload stable while valid is 1 and not
// yet accepted; ready may be driven regardless of valid.
//
// Modports:
//   slave  : the classifier's view (consumes scores, produces results)
//   master : the environment's view (produces scores, consumes results)
// -----------------------------------------------------------------------------
interface argmax_classifier_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  class_idx;
    logic [DATA_W-1:0] class_score;
    logic              frame_err;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        input  out_ready,
        output class_idx,
        output class_score,
        output frame_err
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  class_idx,
        input  class_score,
        input  frame_err
    );

endinterface

// File: rtl/argmax_classifier_score_compare.sv
// -----------------------------------------------------------------------------
// score_compare
// Running-maximum register for one inference frame.
//   clk        : clock
//   rst        : synchronous active-high reset, clears best to 0 / index 0
//   load       : a score transfer happens this cycle
//   first      : this transfer is the first of the frame (loads unconditionally)
//   in_data    : signed score
//   in_idx     : index of this score within the frame
//   best_score : current maximum score
//   best_idx   : index of the current maximum
// -----------------------------------------------------------------------------
module score_compare #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              first,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic [DATA_W-1:0] best_score,
    output logic [IDX_W-1:0]  best_idx
);

    logic greater;

    // Strictly greater: on a tie the earlier (lower) index is kept.
    assign greater = $signed(in_data) > $signed(best_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            best_idx   <= '0;
        end else if (load && (first || greater)) begin
            best_score <= in_data;
            best_idx   <= in_idx;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
// Consumes N_CLASSES signed scores per inference and reports the index and
// value of the maximum, plus a flag when the frame length was wrong.
//   clk       : sole clock, rising edge
//   rstn      : synchronous reset, active-high (1 = in reset)
//   bus       : argmax_classifier_if.slave, score stream in / result out
//   dbg_state : current FSM state, for observation only
//
// Result registers are the running-maximum registers themselves: once the
// frame ends no further transfers occur, so they stay stable through HOLD.
// -----------------------------------------------------------------------------
module argmax_classifier
    import ns_pkg::*;
#(
    parameter int N_CLASSES = NS_N_CLASSES,
    parameter int DATA_W    = NS_DATA_W,
    parameter int IDX_W     = $clog2(N_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rstn,
    argmax_classifier_if.slave    bus,
    output state_t                dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic              frame_err_q;

    logic              xfer;
    logic              last_slot;
    logic              frame_end;
    logic              accept;

    // No score is accepted while reset is held, nor while a result is pending.
    assign bus.in_ready = (state == COLLECT) && !rstn;
    assign bus.out_valid = (state == HOLD);

    assign xfer      = bus.in_valid && bus.in_ready;
    assign last_slot = (cnt == LAST_IDX);
    assign frame_end = xfer && (bus.in_last || last_slot);
    assign accept    = (state == HOLD) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state       <= COLLECT;
            cnt         <= '0;
            frame_err_q <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        if (frame_end) begin
                            state <= HOLD;
                            cnt   <= '0;
                            // Error when in_last and the final slot disagree:
                            // early in_last, or no in_last on the final slot.
                            frame_err_q <= bus.in_last ^ last_slot;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    score_compare #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_score_compare (
        .clk        (clk),
        .rst        (rstn),
        .load       (xfer),
        .first      (cnt == '0),
        .in_data    (bus.in_data),
        .in_idx     (cnt),
        .best_score (bus.class_score),
        .best_idx   (bus.class_idx)
    );

    assign bus.frame_err = frame_err_q;
    assign dbg_state     = state;

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10, meaning the number of output-neuron scores per inference.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the signed score width, equal to the neuron data_out width.
REQ-003 SHALL have parameter IDX_W, default $clog2(N_CLASSES) (4), meaning the class index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-high (asserted = 1).
REQ-006 in_valid  input  1  in_data holds a valid neuron score.
REQ-007 in_data  input  DATA_W  signed score from an output-layer neuron, in index order 0..N_CLASSES-1.
REQ-008 in_last  input  1  marks the final score of an inference.
REQ-009 in_ready  output  1  block accepts a score this cycle.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 class_idx  output  IDX_W  index of the maximum score.
REQ-013 class_score  output  DATA_W  maximum score value.
REQ-014 frame_err  output  1  in_last position did not match N_CLASSES for this result.

Function
REQ-015 An input transfer SHALL occur on a rising edge when in_valid && in_ready.
REQ-016 States SHALL be COLLECT and HOLD; in_ready = 1 in COLLECT, 0 in HOLD.
REQ-017 In COLLECT, a counter cnt (0..N_CLASSES-1) SHALL give the index of the current transfer and increment per transfer.
REQ-018 The first transfer (cnt = 0) SHALL load best_score = in_data, best_idx = 0 unconditionally.
REQ-019 Later transfers SHALL update best only when in_data > best_score (signed compare); ties keep the lower index.
REQ-020 The transfer with in_last = 1, or the transfer at cnt = N_CLASSES-1, whichever is first, SHALL end the frame: next state HOLD, cnt cleared.
REQ-021 frame_err SHALL be set for that result if in_last = 1 with cnt != N_CLASSES-1, or in_last = 0 with cnt = N_CLASSES-1.
REQ-022 The comparison including the terminating score SHALL be included in the result; out_valid rises the cycle after the terminating transfer (latency 1 cycle).
REQ-023 In HOLD, out_valid = 1 and class_idx, class_score, frame_err SHALL remain stable until out_valid && out_ready.
REQ-024 On acceptance, state SHALL return to COLLECT on the next cycle; no input is accepted in the acceptance cycle (one bubble per frame).
REQ-025 in_valid without in_ready SHALL have no effect; in_data is not sampled.
REQ-026 out_ready asserted outside HOLD SHALL have no effect.
REQ-027 Score arithmetic SHALL be full DATA_W signed; no truncation or saturation.

Reset
REQ-028 While rstn = 1 at a clock edge: state = COLLECT, cnt = 0, out_valid = 0, class_idx = 0, class_score = 0, frame_err = 0.
REQ-029 Reset mid-frame or in HOLD SHALL discard partial/pending results with no output produced.
REQ-030 in_ready SHALL be 0 while rstn = 1 and 1 on the first cycle after release.

Structure
REQ-031 N_CLASSES default, DATA_W default and the state enum type SHALL live in the shared project package ns_pkg.
REQ-032 The signed greater-than compare plus best-register update SHALL be one sub-module, score_compare; the FSM and counter remain in argmax_classifier.

Verification
REQ-033 Scores 5,-3,12,7,0,1,2,3,4,11 (last on 10th), out_ready = 1 -> class_idx = 2, class_score = 12, frame_err = 0, out_valid one cycle after 10th transfer.
REQ-034 All ten scores = -8 -> class_idx = 0, class_score = -8 (tie keeps lowest index).
REQ-035 Max 0x7FFFFFFF at index 9, others 0x80000000 -> class_idx = 9, class_score = 0x7FFFFFFF.
REQ-036 in_last on 6th score (max 40 at index 4) -> class_idx = 4, frame_err = 1; next clean frame -> frame_err = 0.
REQ-037 out_ready held 0 for 5 cycles in HOLD with in_valid = 1 -> in_ready = 0, outputs stable, no scores lost or consumed until acceptance.
REQ-038 rstn = 1 after 4th score, then clean 10-score frame -> single result reflecting only the post-reset frame.
